// File: rtl/ps2_pkg.sv
// Shared types, scan-code constants and the set-2 to ASCII lookup for the PS/2 key decoder.
// The lookup is only consumed when PS2_ASCII_EN is defined.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PROC = 2'd2
    } state_t;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    // Returns {valid, ascii}; unmapped codes give all zeros.
    function automatic logic [8:0] ps2_ascii(input logic [7:0] code);
        logic [8:0] r;
        r = 9'h000;
        case (code)
            8'h1C: r = {1'b1, 8'h41};  8'h32: r = {1'b1, 8'h42};
            8'h21: r = {1'b1, 8'h43};  8'h23: r = {1'b1, 8'h44};
            8'h24: r = {1'b1, 8'h45};  8'h2B: r = {1'b1, 8'h46};
            8'h34: r = {1'b1, 8'h47};  8'h33: r = {1'b1, 8'h48};
            8'h43: r = {1'b1, 8'h49};  8'h3B: r = {1'b1, 8'h4A};
            8'h42: r = {1'b1, 8'h4B};  8'h4B: r = {1'b1, 8'h4C};
            8'h3A: r = {1'b1, 8'h4D};  8'h31: r = {1'b1, 8'h4E};
            8'h44: r = {1'b1, 8'h4F};  8'h4D: r = {1'b1, 8'h50};
            8'h15: r = {1'b1, 8'h51};  8'h2D: r = {1'b1, 8'h52};
            8'h1B: r = {1'b1, 8'h53};  8'h2C: r = {1'b1, 8'h54};
            8'h3C: r = {1'b1, 8'h55};  8'h2A: r = {1'b1, 8'h56};
            8'h1D: r = {1'b1, 8'h57};  8'h22: r = {1'b1, 8'h58};
            8'h35: r = {1'b1, 8'h59};  8'h1A: r = {1'b1, 8'h5A};
            8'h45: r = {1'b1, 8'h30};  8'h16: r = {1'b1, 8'h31};
            8'h1E: r = {1'b1, 8'h32};  8'h26: r = {1'b1, 8'h33};
            8'h25: r = {1'b1, 8'h34};  8'h2E: r = {1'b1, 8'h35};
            8'h36: r = {1'b1, 8'h36};  8'h3D: r = {1'b1, 8'h37};
            8'h3E: r = {1'b1, 8'h38};  8'h46: r = {1'b1, 8'h39};
            8'h29: r = {1'b1, 8'h20};  8'h5A: r = {1'b1, 8'h0D};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_bcd_counter.sv
// Multi-digit BCD up-counter with ripple carry; all-nines wraps to zero.
// Shared with the display path.
module ps2_bcd_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   count
);

    logic [4*DIGITS-1:0] count_q;
    logic [4*DIGITS-1:0] count_d;
    logic [DIGITS-1:0]   carry;

    assign carry[0] = inc;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] dig;
            assign dig = count_q[4*gi +: 4];
            assign count_d[4*gi +: 4] = !carry[gi] ? dig :
                                        (dig == 4'd9) ? 4'd0 : dig + 4'd1;
            if (gi < DIGITS - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] && (dig == 4'd9);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: pops FIFO bytes, tracks E0/F0 prefixes, emits key events.
// Define PS2_ASCII_EN to add the ascii/ascii_valid outputs.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int BCD_DIGITS     = 2,
    parameter int PREFIX_TIMEOUT = 1023,
    parameter int TO_W           = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ready,
    input  logic [7:0]                data,
    output logic                      next,
    output logic [7:0]                key_code,
    output logic                      key_ext,
    output logic                      key_down,
    output logic                      make_pulse,
    output logic                      break_pulse,
    output logic                      repeat_pulse,
    output logic                      err_pulse,
`ifdef PS2_ASCII_EN
    output logic [7:0]                ascii,
    output logic                      ascii_valid,
`endif
    output logic [4*BCD_DIGITS-1:0]   press_count
);

    state_t         state_q, state_d;
    logic [7:0]     byte_q, byte_d;
    logic           ext_pend_q, ext_pend_d;
    logic           brk_pend_q, brk_pend_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [7:0]     key_code_q, key_code_d;
    logic           key_ext_q, key_ext_d;
    logic           key_down_q, key_down_d;
    logic           make_q, make_d;
    logic           break_q, break_d;
    logic           repeat_q, repeat_d;
    logic           err_q, err_d;
    logic           pending;
    logic           tmo_hit;
    logic           held_match;

    assign pending    = ext_pend_q || brk_pend_q;
    assign tmo_hit    = (PREFIX_TIMEOUT != 0) && pending && (to_q == TO_W'(PREFIX_TIMEOUT));
    assign held_match = key_down_q && ({ext_pend_q, byte_q} == {key_ext_q, key_code_q});

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        to_d       = to_q;
        key_code_d = key_code_q;
        key_ext_d  = key_ext_q;
        key_down_d = key_down_q;
        make_d     = 1'b0;
        break_d    = 1'b0;
        repeat_d   = 1'b0;
        err_d      = 1'b0;

        // A stale prefix is dropped; every pop restarts the window.
        if (tmo_hit) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
            err_d      = 1'b0 | 1'b1;
            to_d       = '0;
        end else if (state_q == POP) begin
            to_d = '0;
        end else if ((PREFIX_TIMEOUT != 0) && pending) begin
            to_d = to_q + TO_W'(1);
        end

        case (state_q)
            IDLE: if (ready) state_d = POP;
            POP: begin
                byte_d  = data;
                state_d = PROC;
            end
            PROC: begin
                state_d = IDLE;
                if (byte_q == PS2_EXT) begin
                    ext_pend_d = 1'b1;
                end else if (byte_q == PS2_BRK) begin
                    brk_pend_d = 1'b1;
                end else begin
                    ext_pend_d = 1'b0;
                    brk_pend_d = 1'b0;
                    if (byte_q == PS2_ERR0 || byte_q == PS2_ERR1) begin
                        err_d = 1'b1;
                    end else if (brk_pend_q) begin
                        if (held_match) begin
                            break_d    = 1'b1;
                            key_down_d = 1'b0;
                        end
                    end else if (held_match) begin
                        repeat_d = 1'b1;
                    end else begin
                        make_d     = 1'b1;
                        key_code_d = byte_q;
                        key_ext_d  = ext_pend_q;
                        key_down_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            to_q       <= '0;
            key_code_q <= '0;
            key_ext_q  <= 1'b0;
            key_down_q <= 1'b0;
            make_q     <= 1'b0;
            break_q    <= 1'b0;
            repeat_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            to_q       <= to_d;
            key_code_q <= key_code_d;
            key_ext_q  <= key_ext_d;
            key_down_q <= key_down_d;
            make_q     <= make_d;
            break_q    <= break_d;
            repeat_q   <= repeat_d;
            err_q      <= err_d;
        end
    end

    // Strobe decoded straight from the state register so reset drops it at once.
    assign next         = (state_q == POP);
    assign key_code     = key_code_q;
    assign key_ext      = key_ext_q;
    assign key_down     = key_down_q;
    assign make_pulse   = make_q;
    assign break_pulse  = break_q;
    assign repeat_pulse = repeat_q;
    assign err_pulse    = err_q;

    ps2_bcd_counter #(
        .DIGITS (BCD_DIGITS)
    ) u_press_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (make_d),
        .count (press_count)
    );

`ifdef PS2_ASCII_EN
    logic [7:0] ascii_q;
    logic       ascii_valid_q;
    logic [8:0] lut;

    assign lut = ps2_ascii(byte_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ascii_q       <= '0;
            ascii_valid_q <= 1'b0;
        end else if (make_d) begin
            ascii_q       <= ext_pend_q ? 8'h00 : lut[7:0];
            ascii_valid_q <= ext_pend_q ? 1'b0 : lut[8];
        end
    end

    assign ascii       = ascii_q;
    assign ascii_valid = ascii_valid_q;
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed vector table, hand sequences and random bytes.
module tb_ps2_key_decoder;

    localparam int DIG = 2;
    localparam int TMO = 20;
    localparam int EV_NONE = 0, EV_MAKE = 1, EV_BREAK = 2, EV_REPEAT = 3, EV_ERR = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ready;
    logic [7:0]       data;
    logic             next;
    logic [7:0]       key_code;
    logic             key_ext, key_down;
    logic             make_pulse, break_pulse, repeat_pulse, err_pulse;
    logic [4*DIG-1:0] press_count;
`ifdef PS2_ASCII_EN
    logic [7:0]       ascii;
    logic             ascii_valid;
`endif

    ps2_key_decoder #(
        .BCD_DIGITS     (DIG),
        .PREFIX_TIMEOUT (TMO),
        .TO_W           (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ready        (ready),
        .data         (data),
        .next         (next),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_down     (key_down),
        .make_pulse   (make_pulse),
        .break_pulse  (break_pulse),
        .repeat_pulse (repeat_pulse),
        .err_pulse    (err_pulse),
`ifdef PS2_ASCII_EN
        .ascii        (ascii),
        .ascii_valid  (ascii_valid),
`endif
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int last_pop = -100;

    // Reference model: held key as a 9-bit {ext,code} value, prefixes as plain flags.
    int m_held, m_down, m_count, m_ext_p, m_brk_p;

    task automatic model_reset();
        m_held = 0; m_down = 0; m_count = 0; m_ext_p = 0; m_brk_p = 0;
        last_pop = -100;
    endtask

    function automatic int model_byte(input logic [7:0] b);
        int key, ev;
        if (b == 8'hE0) begin m_ext_p = 1; return EV_NONE; end
        if (b == 8'hF0) begin m_brk_p = 1; return EV_NONE; end
        if (b == 8'h00 || b == 8'hFF) begin m_ext_p = 0; m_brk_p = 0; return EV_ERR; end
        key = m_ext_p * 256 + int'(b);
        if (m_brk_p != 0) begin
            ev = (m_down != 0 && key == m_held) ? EV_BREAK : EV_NONE;
            if (ev == EV_BREAK) m_down = 0;
        end else if (m_down != 0 && key == m_held) begin
            ev = EV_REPEAT;
        end else begin
            ev = EV_MAKE;
            m_held = key;
            m_down = 1;
            m_count = (m_count + 1) % (10 ** DIG);
        end
        m_ext_p = 0; m_brk_p = 0;
        return ev;
    endfunction

    function automatic int bcd_value();
        int v = 0, p = 1;
        for (int i = 0; i < DIG; i++) begin
            if (press_count[4*i +: 4] > 4'd9) return -1;
            v += int'(press_count[4*i +: 4]) * p;
            p *= 10;
        end
        return v;
    endfunction

    function automatic int observed_ev();
        int n = int'(make_pulse) + int'(break_pulse) + int'(repeat_pulse) + int'(err_pulse);
        if (n > 1) return -1;
        if (make_pulse)   return EV_MAKE;
        if (break_pulse)  return EV_BREAK;
        if (repeat_pulse) return EV_REPEAT;
        if (err_pulse)    return EV_ERR;
        return EV_NONE;
    endfunction

    task automatic check_out(input string name, input int ev, input logic [7:0] code,
                             input logic ext, input logic down, input int cnt);
        int got_ev, got_cnt;
        got_ev  = observed_ev();
        got_cnt = bcd_value();
        vectors++;
        if (got_ev != ev || key_code !== code || key_ext !== ext || key_down !== down ||
            got_cnt != cnt || next !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: got ev=%0d code=%h ext=%b down=%b cnt=%0d next=%b, required ev=%0d code=%h ext=%b down=%b cnt=%0d next=0",
                     name, got_ev, key_code, key_ext, key_down, got_cnt, next, ev, code, ext, down, cnt);
        end
    endtask

    task automatic check_model(input string name, input int ev);
        check_out(name, ev, m_held[7:0], m_held[8], m_down[0], m_count);
    endtask

    // Hands one byte to the DUT; returns with outputs of that byte visible (IDLE cycle, negedge).
    task automatic pop_byte(input logic [7:0] b, input string name, output bit ok);
        bit seen = 0;
        data  = b;
        ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (next === 1'b1) begin seen = 1; break; end
        end
        ok = seen;
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL %s: no next strobe within 20 cycles, required one", name);
            ready = 1'b0;
            return;
        end
        if (last_pop >= 0) begin
            vectors++;
            if (cyc - last_pop < 3) begin
                miscompares++;
                $display("FAIL %s spacing: got %0d cycles between pops, required >=3", name, cyc - last_pop);
            end
        end
        last_pop = cyc;
        @(negedge clk);
        vectors++;
        if (next !== 1'b0) begin
            miscompares++;
            $display("FAIL %s strobe_len: got next=%b in PROC, required 0", name, next);
        end
        @(negedge clk);
        $display("tx %s byte=%h make=%b brk=%b rep=%b err=%b code=%h ext=%b down=%b cnt=%h",
                 name, b, make_pulse, break_pulse, repeat_pulse, err_pulse, key_code, key_ext, key_down, press_count);
    endtask

    task automatic send_model(input logic [7:0] b, input string name);
        bit ok;
        int ev;
        pop_byte(b, name, ok);
        ev = model_byte(b);
        if (ok) check_model(name, ev);
    endtask

    task automatic idle(input int n);
        ready = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        ready = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    typedef struct {
        bit         rst_before;
        logic [7:0] b;
        int         ev;
        logic [7:0] code;
        logic       ext;
        logic       down;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input logic [7:0] b, input int ev, input logic [7:0] code,
                       input logic ext, input logic down, input int cnt);
        vec_t v;
        v.rst_before = r; v.b = b; v.ev = ev; v.code = code; v.ext = ext; v.down = down; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pool [9];
        logic [7:0] exp_bcd [3];
        bit ok, seen;
        int k, ev;

        // Plain make/break, extended make/break, typematic repeats.
        add(1, 8'h1C, EV_MAKE,   8'h1C, 0, 1, 1);
        add(0, 8'hF0, EV_NONE,   8'h1C, 0, 1, 1);
        add(0, 8'h1C, EV_BREAK,  8'h1C, 0, 0, 1);
        add(1, 8'hE0, EV_NONE,   8'h00, 0, 0, 0);
        add(0, 8'h75, EV_MAKE,   8'h75, 1, 1, 1);
        add(0, 8'hE0, EV_NONE,   8'h75, 1, 1, 1);
        add(0, 8'hF0, EV_NONE,   8'h75, 1, 1, 1);
        add(0, 8'h75, EV_BREAK,  8'h75, 1, 0, 1);
        add(1, 8'h1C, EV_MAKE,   8'h1C, 0, 1, 1);
        add(0, 8'h1C, EV_REPEAT, 8'h1C, 0, 1, 1);
        add(0, 8'h1C, EV_REPEAT, 8'h1C, 0, 1, 1);
        add(0, 8'hF0, EV_NONE,   8'h1C, 0, 1, 1);
        add(0, 8'h1C, EV_BREAK,  8'h1C, 0, 0, 1);
        add(0, 8'hFF, EV_ERR,    8'h1C, 0, 0, 1);

        rst = 1'b1; ready = 1'b0; data = 8'h00;
        do_reset();
        check_out("reset", EV_NONE, 8'h00, 1'b0, 1'b0, 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            pop_byte(tbl[i].b, $sformatf("tbl%0d", i), ok);
            ev = model_byte(tbl[i].b);
            if (ok) check_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].code, tbl[i].ext, tbl[i].down, tbl[i].cnt);
        end
        idle(2);

        // 100 distinct make/break pairs: press_count must roll 98 -> 99 -> 00.
        do_reset();
        exp_bcd[0] = 8'h98; exp_bcd[1] = 8'h99; exp_bcd[2] = 8'h00;
        for (int i = 0; i < 100; i++) begin
            send_model(8'(i + 1), $sformatf("bcd_make%0d", i));
            if (i >= 97) begin
                vectors++;
                if (press_count !== exp_bcd[i-97]) begin
                    miscompares++;
                    $display("FAIL bcd_wrap%0d: got %h, required %h", i, press_count, exp_bcd[i-97]);
                end
            end
            send_model(8'hF0, "bcd_f0");
            send_model(8'(i + 1), $sformatf("bcd_break%0d", i));
        end
        idle(2);

        // Stale F0 prefix must time out with err_pulse; the next 1C is a make.
        do_reset();
        send_model(8'hF0, "tmo_f0");
        ready = 1'b0;
        seen = 0; k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (err_pulse === 1'b1) begin seen = 1; k = i; break; end
        end
        vectors++;
        if (!seen || k < TMO || k > TMO + 2) begin
            miscompares++;
            $display("FAIL prefix_timeout: got err after %0d cycles (seen=%0d), required %0d..%0d", k, seen, TMO, TMO + 2);
        end
        m_ext_p = 0; m_brk_p = 0;
        @(negedge clk);
        vectors++;
        if (err_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL err_len: got err_pulse=%b one cycle later, required 0", err_pulse);
        end
        send_model(8'h1C, "tmo_1c");
        idle(2);

        // Reset in the middle of a POP with a held key and count 42.
        do_reset();
        for (int i = 0; i < 42; i++) send_model(8'(i + 1), $sformatf("pre42_%0d", i));
        vectors++;
        if (press_count !== 8'h42 || key_down !== 1'b1) begin
            miscompares++;
            $display("FAIL count42: got cnt=%h down=%b, required 42 and 1", press_count, key_down);
        end
        data = 8'h33; ready = 1'b1; seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (next === 1'b1) begin seen = 1; break; end
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (!seen || next !== 1'b0 || key_down !== 1'b0 || key_code !== 8'h00 || press_count !== 8'h00 ||
            make_pulse !== 1'b0 || break_pulse !== 1'b0 || repeat_pulse !== 1'b0 || err_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_in_pop: got seen=%0d next=%b down=%b code=%h cnt=%h, required pop seen and all zero",
                     seen, next, key_down, key_code, press_count);
        end
        ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        send_model(8'h1C, "post_rst");
        idle(2);

        // Random bytes drawn from a pool that mixes prefixes, errors and a few keys.
        pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h00; pool[3] = 8'hFF; pool[4] = 8'h1C;
        pool[5] = 8'h1D; pool[6] = 8'h75; pool[7] = 8'h29; pool[8] = 8'h5A;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send_model(pool[$urandom_range(8, 0)], $sformatf("rnd%0d", i));
            if ($urandom_range(3, 0) == 0) idle($urandom_range(3, 1));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
